// File: rtl/rr_mux_arbiter_4_if.sv
// Handshake bundle for the four-channel round-robin arbiter: four valid/ready
// input channels plus the single registered output slot.
interface rr_mux_arbiter_4_if #(
   parameter int WIDTH = 4
);
   logic [3:0]       in_valid;
   logic [3:0]       in_ready;
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic [WIDTH-1:0] d3;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_src;

   // Arbiter side
   modport master (
      input  in_valid, d0, d1, d2, d3, out_ready,
      output in_ready, out_valid, out_data, out_src
   );

   // Surrounding producers and consumer
   modport slave (
      output in_valid, d0, d1, d2, d3, out_ready,
      input  in_ready, out_valid, out_data, out_src
   );
endinterface

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter over four valid/ready channels feeding a single-entry
// registered output slot; the granted index drives a 4:1 data select.
module rr_mux_arbiter_4 #(
   parameter int WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   rr_mux_arbiter_4_if.master  bus
);

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [1:0]       out_src_q,   out_src_d;
   logic [1:0]       last_q,      last_d;

   logic             load;
   logic             grant_vld;
   logic [1:0]       grant;
   logic [WIDTH-1:0] grant_data;
   logic [3:0]       ready;

   function automatic logic [WIDTH-1:0] mux_4_1(
      input logic [1:0]       sel,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic [WIDTH-1:0] c,
      input logic [WIDTH-1:0] e
   );
      case (sel)
         2'd0:    mux_4_1 = a;
         2'd1:    mux_4_1 = b;
         2'd2:    mux_4_1 = c;
         default: mux_4_1 = e;
      endcase
   endfunction

   // Returns {found, index}. Scans from lowest to highest priority so the
   // last hit written is the winner: last+1 first, last itself last.
   function automatic logic [2:0] rr_pick(
      input logic [1:0] last,
      input logic [3:0] req
   );
      logic [1:0] idx;
      rr_pick = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (req[idx]) rr_pick = {1'b1, idx};
      end
   endfunction

   always_comb begin
      load                = !out_valid_q || bus.out_ready;
      {grant_vld, grant}  = rr_pick(last_q, bus.in_valid);
      grant_data          = mux_4_1(grant, bus.d0, bus.d1, bus.d2, bus.d3);
      ready               = 4'b0000;
      // Reset clears the slot (so load rises); keep ready low until release.
      if (load && grant_vld && !rst) ready[grant] = 1'b1;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      last_d      = last_q;
      if (load) begin
         if (grant_vld) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_src_d   = grant;
            last_d      = grant;
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= 2'd0;
         last_q      <= 2'd3;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         last_q      <= last_d;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Directed bench for rr_mux_arbiter_4: inputs change on the falling edge,
// outputs are checked on the falling edge (registered) or 1ns after a drive.
module tb_rr_mux_arbiter_4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   rr_mux_arbiter_4_if #(.WIDTH(4)) bus ();

   rr_mux_arbiter_4 #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      bus.in_valid  = 4'b1111;
      bus.d0 = 4'h1; bus.d1 = 4'h2; bus.d2 = 4'h3; bus.d3 = 4'h4;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_in_ready: got %b expected 0000", bus.in_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      checks++;
      if (bus.out_data !== 4'h0) begin
         errors++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data);
      end
      checks++;
      if (bus.out_src !== 2'd0) begin
         errors++; $display("FAIL reset_out_src: got %0d expected 0", bus.out_src);
      end
      checks++;
      if (bus.in_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_in_ready_hold: got %b expected 0000", bus.in_ready);
      end
   endtask

   // Leaves last = 1 with slot {src 1, data 2}.
   task automatic test_round_robin();
      logic [1:0] exp_src;
      logic [3:0] exp_data;
      logic [3:0] exp_rdy;
      rst = 1'b0;
      #1;
      checks++;
      if (bus.in_ready !== 4'b0001) begin
         errors++; $display("FAIL rr_first_ready: got %b expected 0001", bus.in_ready);
      end
      for (int i = 0; i < 6; i++) begin
         exp_src  = 2'(i % 4);
         exp_data = 4'(i % 4 + 1);
         exp_rdy  = 4'b0001 << ((i + 1) % 4);
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_src !== exp_src || bus.out_data !== exp_data) begin
            errors++;
            $display("FAIL rr_step%0d: got valid=%b src=%0d data=%h expected valid=1 src=%0d data=%h",
                     i, bus.out_valid, bus.out_src, bus.out_data, exp_src, exp_data);
         end
         #1;
         checks++;
         if (bus.in_ready !== exp_rdy) begin
            errors++; $display("FAIL rr_ready%0d: got %b expected %b", i, bus.in_ready, exp_rdy);
         end
      end
   endtask

   // Leaves last = 2 with slot {src 2, data A}.
   task automatic test_single_requester();
      bus.in_valid = 4'b0100;
      bus.d2       = 4'hA;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (bus.in_ready !== 4'b0100) begin
            errors++; $display("FAIL single_ready%0d: got %b expected 0100", i, bus.in_ready);
         end
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd2 || bus.out_data !== 4'hA) begin
            errors++;
            $display("FAIL single_out%0d: got valid=%b src=%0d data=%h expected valid=1 src=2 data=a",
                     i, bus.out_valid, bus.out_src, bus.out_data);
         end
      end
   endtask

   // Loads slot {5, src 1}, stalls 3 cycles, then expects channel 2 next.
   task automatic test_backpressure();
      bus.in_valid  = 4'b0010;
      bus.d1        = 4'h5;
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.out_src !== 2'd1 || bus.out_data !== 4'h5) begin
         errors++; $display("FAIL bp_setup: got src=%0d data=%h expected src=1 data=5", bus.out_src, bus.out_data);
      end
      bus.out_ready = 1'b0;
      bus.in_valid  = 4'b1111;
      bus.d0 = 4'h6; bus.d1 = 4'h7; bus.d2 = 4'h8; bus.d3 = 4'h9;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus.in_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_ready%0d: got %b expected 0000", i, bus.in_ready);
         end
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd1 || bus.out_data !== 4'h5) begin
            errors++;
            $display("FAIL bp_hold%0d: got valid=%b src=%0d data=%h expected valid=1 src=1 data=5",
                     i, bus.out_valid, bus.out_src, bus.out_data);
         end
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 4'b0100) begin
         errors++; $display("FAIL bp_release_ready: got %b expected 0100", bus.in_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.out_src !== 2'd2 || bus.out_data !== 4'h8) begin
         errors++; $display("FAIL bp_release_out: got src=%0d data=%h expected src=2 data=8", bus.out_src, bus.out_data);
      end
   endtask

   // Sets last = 1 via a lone channel-1 grant, then alternates 3,1,3,1.
   task automatic test_sparse();
      logic [1:0] exp_seq [4] = '{2'd3, 2'd1, 2'd3, 2'd1};
      logic [3:0] exp_data;
      bus.in_valid = 4'b0010;
      bus.d1       = 4'hB;
      @(negedge clk);
      checks++;
      if (bus.out_src !== 2'd1 || bus.out_data !== 4'hB) begin
         errors++; $display("FAIL sparse_setup: got src=%0d data=%h expected src=1 data=b", bus.out_src, bus.out_data);
      end
      bus.in_valid = 4'b1010;
      bus.d1 = 4'h1; bus.d3 = 4'h3;
      for (int i = 0; i < 4; i++) begin
         exp_data = (exp_seq[i] == 2'd3) ? 4'h3 : 4'h1;
         #1;
         checks++;
         if (bus.in_ready !== (4'b0001 << exp_seq[i])) begin
            errors++; $display("FAIL sparse_ready%0d: got %b expected %b", i, bus.in_ready, 4'b0001 << exp_seq[i]);
         end
         @(negedge clk);
         checks++;
         if (bus.out_src !== exp_seq[i] || bus.out_data !== exp_data) begin
            errors++;
            $display("FAIL sparse_out%0d: got src=%0d data=%h expected src=%0d data=%h",
                     i, bus.out_src, bus.out_data, exp_seq[i], exp_data);
         end
      end
   endtask

   // Slot holds {src 1, data 1} on entry.
   task automatic test_empty();
      bus.in_valid  = 4'b0000;
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 4'b0000) begin
         errors++; $display("FAIL empty_ready: got %b expected 0000", bus.in_ready);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h1 || bus.out_src !== 2'd1) begin
            errors++;
            $display("FAIL empty_out%0d: got valid=%b src=%0d data=%h expected valid=0 src=1 data=1",
                     i, bus.out_valid, bus.out_src, bus.out_data);
         end
      end
   endtask

   task automatic test_reset_mid();
      bus.in_valid = 4'b0100;
      bus.d2       = 4'hC;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd2 || bus.out_data !== 4'hC) begin
         errors++;
         $display("FAIL midrst_setup: got valid=%b src=%0d data=%h expected valid=1 src=2 data=c",
                  bus.out_valid, bus.out_src, bus.out_data);
      end
      bus.in_valid  = 4'b1111;
      bus.out_ready = 1'b0;
      bus.d0 = 4'h1; bus.d1 = 4'h2; bus.d2 = 4'h3; bus.d3 = 4'h4;
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 || bus.out_src !== 2'd0) begin
         errors++;
         $display("FAIL midrst_clear: got valid=%b src=%0d data=%h expected valid=0 src=0 data=0",
                  bus.out_valid, bus.out_src, bus.out_data);
      end
      checks++;
      if (bus.in_ready !== 4'b0000) begin
         errors++; $display("FAIL midrst_ready: got %b expected 0000", bus.in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 4'b0001) begin
         errors++; $display("FAIL midrst_first_ready: got %b expected 0001", bus.in_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_src !== 2'd0 || bus.out_data !== 4'h1) begin
         errors++;
         $display("FAIL midrst_first_out: got valid=%b src=%0d data=%h expected valid=1 src=0 data=1",
                  bus.out_valid, bus.out_src, bus.out_data);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_requester();
      test_backpressure();
      test_sparse();
      test_empty();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
